// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write ports among FU0..FU2 and the LSU.
// Each requester owns a small skid FIFO; a round-robin scan grants up to NUM_WP
// eligible heads per cycle onto registered write-port packets. Branch masks are
// squashed or cleared in place on branch resolution.
// Optional feature: define WB_ARB_PERF_EN to enable the perf_stall_o/perf_squash_o
// saturating counters (otherwise both outputs are tied to zero).
module wb_port_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned NUM_WP    = 2,
   parameter int unsigned BUF_DEPTH = 2,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned PHYS_W    = 7,
   parameter int unsigned AL_W      = 7,
   parameter int unsigned CKPT      = 8,
   parameter int unsigned CKPT_LOG  = 3
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_REQ-1:0]                          req_valid_i,
   input  logic [NUM_REQ*(CKPT+PHYS_W+AL_W+DATA_W)-1:0] req_packet_i,
   output logic [NUM_REQ-1:0]                          req_ready_o,
   input  logic                                        ctrlVerified_i,
   input  logic                                        ctrlMispredict_i,
   input  logic [CKPT_LOG-1:0]                         ctrlSMTid_i,
   output logic [NUM_WP-1:0]                           wp_valid_o,
   output logic [NUM_WP*(PHYS_W+AL_W+DATA_W)-1:0]      wp_packet_o,
   output logic [NUM_WP*2-1:0]                         wp_src_o,
   output logic [31:0]                                 perf_stall_o,
   output logic [31:0]                                 perf_squash_o
);
   localparam int unsigned PKT_W = CKPT + PHYS_W + AL_W + DATA_W;
   localparam int unsigned OUT_W = PHYS_W + AL_W + DATA_W;
   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned REQ_W = 2;  // width of each wp_src_o field
   localparam int unsigned WP_W  = (NUM_WP > 1) ? $clog2(NUM_WP) : 1;
   localparam int unsigned GW    = WP_W + 1;

   logic [OUT_W-1:0]     pay_q  [NUM_REQ][BUF_DEPTH];
   logic [CKPT-1:0]      mask_q [NUM_REQ][BUF_DEPTH];
   logic [CKPT-1:0]      mask_s [NUM_REQ][BUF_DEPTH];
   logic [CKPT-1:0]      mask_d [NUM_REQ][BUF_DEPTH];
   logic [BUF_DEPTH-1:0] vld_q  [NUM_REQ];
   logic [BUF_DEPTH-1:0] vld_s  [NUM_REQ];
   logic [BUF_DEPTH-1:0] vld_d  [NUM_REQ];
   logic [PTR_W-1:0]     wptr_q [NUM_REQ];
   logic [PTR_W-1:0]     wptr_d [NUM_REQ];
   logic [PTR_W-1:0]     rptr_q [NUM_REQ];
   logic [PTR_W-1:0]     rptr_d [NUM_REQ];
   logic [CNT_W-1:0]     cnt_q  [NUM_REQ];
   logic [CNT_W-1:0]     cnt_d  [NUM_REQ];
   logic [CKPT-1:0]      in_mask[NUM_REQ];
   logic [REQ_W-1:0]     rr_q, rr_d;
   logic [NUM_WP-1:0]    wp_valid_q, wp_valid_d;
   logic [OUT_W-1:0]     wp_pay_q [NUM_WP];
   logic [OUT_W-1:0]     wp_pay_d [NUM_WP];
   logic [REQ_W-1:0]     wp_src_q [NUM_WP];
   logic [REQ_W-1:0]     wp_src_d [NUM_WP];
   logic [NUM_REQ-1:0]   push, pop, elig, gnt, in_sq;
   logic                 mispred, correct;
   logic [CKPT-1:0]      keep_mask;
   logic [REQ_W-1:0]     idx, last;
   logic [GW-1:0]        ngnt;

   assign mispred   = ctrlVerified_i & ctrlMispredict_i;
   assign correct   = ctrlVerified_i & ~ctrlMispredict_i;
   assign keep_mask = correct ? ~(CKPT'(1) << ctrlSMTid_i) : '1;

   // Apply squash/clear to stored entries, decode incoming masks, find eligible heads
   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         req_ready_o[r] = (cnt_q[r] < CNT_W'(BUF_DEPTH));
         push[r]        = req_valid_i[r] & req_ready_o[r];
         in_mask[r]     = req_packet_i[r*PKT_W + OUT_W +: CKPT];
         in_sq[r]       = mispred & in_mask[r][ctrlSMTid_i];
         for (int e = 0; e < BUF_DEPTH; e++) begin
            vld_s[r][e]  = vld_q[r][e] & ~(mispred & mask_q[r][e][ctrlSMTid_i]);
            mask_s[r][e] = mask_q[r][e] & keep_mask;
         end
         // A head squashed this cycle is not eligible; no bypass from the push path
         elig[r] = (cnt_q[r] != '0) & vld_s[r][rptr_q[r]];
      end
   end

   // Round-robin scan from rr_q; first NUM_WP eligible heads take ports in order
   always_comb begin
      gnt        = '0;
      wp_valid_d = '0;
      ngnt       = '0;
      idx        = '0;
      last       = rr_q;
      for (int p = 0; p < NUM_WP; p++) begin
         wp_pay_d[p] = wp_pay_q[p];
         wp_src_d[p] = wp_src_q[p];
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = REQ_W'((32'(rr_q) + i) % NUM_REQ);
         if (elig[idx] && (ngnt < GW'(NUM_WP))) begin
            gnt[idx]                   = 1'b1;
            wp_valid_d[ngnt[WP_W-1:0]] = 1'b1;
            wp_pay_d[ngnt[WP_W-1:0]]   = pay_q[idx][rptr_q[idx]];
            wp_src_d[ngnt[WP_W-1:0]]   = idx;
            ngnt                       = ngnt + GW'(1);
            last                       = idx;
         end
      end
      if (ngnt == '0) begin
         rr_d = rr_q;
      end else if (32'(last) == NUM_REQ - 1) begin
         rr_d = '0;
      end else begin
         rr_d = last + REQ_W'(1);
      end
   end

   // FIFO next state: pop granted or dead heads, push at tail with resolved mask
   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         vld_d[r]  = vld_s[r];
         wptr_d[r] = wptr_q[r];
         rptr_d[r] = rptr_q[r];
         for (int e = 0; e < BUF_DEPTH; e++) begin
            mask_d[r][e] = mask_s[r][e];
         end
         pop[r] = (cnt_q[r] != '0) & (gnt[r] | ~elig[r]);
         if (pop[r]) begin
            vld_d[r][rptr_q[r]] = 1'b0;
            rptr_d[r]           = rptr_q[r] + PTR_W'(1);
         end
         if (push[r]) begin
            vld_d[r][wptr_q[r]]  = ~in_sq[r];
            mask_d[r][wptr_q[r]] = in_mask[r] & keep_mask;
            wptr_d[r]            = wptr_q[r] + PTR_W'(1);
         end
         cnt_d[r] = cnt_q[r] + CNT_W'(push[r]) - CNT_W'(pop[r]);
      end
   end

   // Control state and registered write-port outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q       <= '0;
         wp_valid_q <= '0;
         for (int r = 0; r < NUM_REQ; r++) begin
            vld_q[r]  <= '0;
            wptr_q[r] <= '0;
            rptr_q[r] <= '0;
            cnt_q[r]  <= '0;
            for (int e = 0; e < BUF_DEPTH; e++) begin
               mask_q[r][e] <= '0;
            end
         end
         for (int p = 0; p < NUM_WP; p++) begin
            wp_pay_q[p] <= '0;
            wp_src_q[p] <= '0;
         end
      end else begin
         rr_q       <= rr_d;
         wp_valid_q <= wp_valid_d;
         vld_q      <= vld_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         wp_pay_q   <= wp_pay_d;
         wp_src_q   <= wp_src_d;
      end
   end

   // Payload storage; contents are qualified by the valid bits, so no reset
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REQ; r++) begin
         if (push[r]) begin
            pay_q[r][wptr_q[r]] <= req_packet_i[r*PKT_W +: OUT_W];
         end
      end
   end

   assign wp_valid_o = wp_valid_q;
   for (genvar p = 0; p < NUM_WP; p++) begin : g_wp
      assign wp_packet_o[p*OUT_W +: OUT_W] = wp_pay_q[p];
      assign wp_src_o[p*REQ_W +: REQ_W]    = wp_src_q[p];
   end

`ifdef WB_ARB_PERF_EN
   logic [31:0] stall_q, squash_q, sq_cnt;
   logic [32:0] squash_sum;

   // Entries killed this cycle: valid stored entries plus squashed incoming pushes
   always_comb begin
      sq_cnt = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         for (int e = 0; e < BUF_DEPTH; e++) begin
            sq_cnt = sq_cnt + 32'(vld_q[r][e] & ~vld_s[r][e]);
         end
         sq_cnt = sq_cnt + 32'(push[r] & in_sq[r]);
      end
   end

   assign squash_sum = {1'b0, squash_q} + {1'b0, sq_cnt};

   // Saturating stall and squash counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= '0;
         squash_q <= '0;
      end else begin
         if ((|(req_valid_i & ~req_ready_o)) && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
         end
         squash_q <= squash_sum[32] ? '1 : squash_sum[31:0];
      end
   end

   assign perf_stall_o  = stall_q;
   assign perf_squash_o = squash_q;
`else
   assign perf_stall_o  = '0;
   assign perf_squash_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (NUM_REQ=4, NUM_WP=2, BUF_DEPTH=2).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_wb_port_arbiter;
   logic         clk;
   logic         reset;
   logic [3:0]   req_valid;
   logic [215:0] req_packet;
   logic [3:0]   req_ready;
   logic         ctrl_v, ctrl_m;
   logic [2:0]   ctrl_id;
   logic [1:0]   wp_valid;
   logic [91:0]  wp_packet;
   logic [3:0]   wp_src;
   logic [31:0]  perf_stall, perf_squash;

   int checks   = 0;
   int failures = 0;

`ifdef WB_ARB_PERF_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   wb_port_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid_i     (req_valid),
      .req_packet_i    (req_packet),
      .req_ready_o     (req_ready),
      .ctrlVerified_i  (ctrl_v),
      .ctrlMispredict_i(ctrl_m),
      .ctrlSMTid_i     (ctrl_id),
      .wp_valid_o      (wp_valid),
      .wp_packet_o     (wp_packet),
      .wp_src_o        (wp_src),
      .perf_stall_o    (perf_stall),
      .perf_squash_o   (perf_squash)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [53:0] mk(logic [7:0] m, logic [6:0] phy, logic [6:0] al,
                                      logic [31:0] d);
      return {m, phy, al, d};
   endfunction

   function automatic logic [45:0] opkt(int p);
      return wp_packet[p*46 +: 46];
   endfunction

   function automatic logic [1:0] osrc(int p);
      return wp_src[p*2 +: 2];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int r, input logic [53:0] p);
      req_packet[r*54 +: 54] = p;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid  = '0;
      req_packet = '0;
      ctrl_v     = 1'b0;
      ctrl_m     = 1'b0;
      ctrl_id    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int          k[4];
   logic [3:0]  rdy;
   logic [3:0]  exp_rdy;
   int          s0, seq;

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      // Reset state
      chk("rst_valid", 64'(wp_valid), 64'h0);
      chk("rst_packet", 64'(wp_packet[63:0]), 64'h0);
      chk("rst_src", 64'(wp_src), 64'h0);
      chk("rst_ready", 64'(req_ready), 64'hF);
      chk("rst_stall", 64'(perf_stall), 64'h0);
      chk("rst_squash", 64'(perf_squash), 64'h0);
      reset = 1'b0;

      // Single push on requester 0: output two edges later
      req_valid = 4'b0001;
      drive(0, mk(8'h00, 7'd3, 7'd5, 32'hA5));
      tick();
      idle_inputs();
      chk("t1_latency_valid", 64'(wp_valid), 64'h0);
      tick();
      chk("t1_valid", 64'(wp_valid), 64'h1);
      chk("t1_src0", 64'(osrc(0)), 64'h0);
      chk("t1_pkt0", 64'(opkt(0)), 64'({7'd3, 7'd5, 32'hA5}));
      chk("t1_pkt1_hold", 64'(opkt(1)), 64'h0);
      tick();
      chk("t1_idle_valid", 64'(wp_valid), 64'h0);
      chk("t1_pkt0_hold", 64'(opkt(0)), 64'({7'd3, 7'd5, 32'hA5}));

      // Saturating traffic: all four requesters hold valid for 13 edges
      do_reset();
      for (int r = 0; r < 4; r++) k[r] = 0;
      for (int n = 1; n <= 13; n++) begin
         rdy       = req_ready;
         req_valid = 4'hF;
         for (int r = 0; r < 4; r++) drive(r, mk(8'h00, 7'(r), 7'd0, 32'(r*256 + k[r] + 1)));
         tick();
         for (int r = 0; r < 4; r++) if (rdy[r]) k[r]++;
         exp_rdy = (n == 1) ? 4'hF : ((n % 2 == 0) ? 4'h3 : 4'hC);
         chk($sformatf("tr_ready_n%0d", n), 64'(req_ready), 64'(exp_rdy));
         if (n >= 2) begin
            s0  = (n % 2 == 0) ? 0 : 2;
            seq = (n % 2 == 0) ? (n - 2) / 2 : (n - 3) / 2;
            chk($sformatf("tr_valid_n%0d", n), 64'(wp_valid), 64'h3);
            chk($sformatf("tr_src0_n%0d", n), 64'(osrc(0)), 64'(s0));
            chk($sformatf("tr_src1_n%0d", n), 64'(osrc(1)), 64'(s0 + 1));
            chk($sformatf("tr_pkt0_n%0d", n), 64'(opkt(0)),
                64'({7'(s0), 7'd0, 32'(s0*256 + seq + 1)}));
            chk($sformatf("tr_pkt1_n%0d", n), 64'(opkt(1)),
                64'({7'(s0 + 1), 7'd0, 32'((s0 + 1)*256 + seq + 1)}));
         end else begin
            chk("tr_valid_n1", 64'(wp_valid), 64'h0);
         end
      end
      chk("tr_stall_count", 64'(perf_stall), PerfEn ? 64'd11 : 64'd0);

      // Reset mid-operation with FIFOs occupied
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_valid", 64'(wp_valid), 64'h0);
      chk("mr_packet", 64'(wp_packet[63:0]), 64'h0);
      chk("mr_src", 64'(wp_src), 64'h0);
      chk("mr_ready", 64'(req_ready), 64'hF);
      chk("mr_stall", 64'(perf_stall), 64'h0);
      req_valid = 4'b0111;
      drive(0, mk(8'h00, 7'd0, 7'd0, 32'h30));
      drive(1, mk(8'h00, 7'd1, 7'd0, 32'h31));
      drive(2, mk(8'h00, 7'd2, 7'd0, 32'h32));
      tick();
      idle_inputs();
      tick();
      chk("mr_g_valid", 64'(wp_valid), 64'h3);
      chk("mr_g_src0", 64'(osrc(0)), 64'h0);
      chk("mr_g_src1", 64'(osrc(1)), 64'h1);
      chk("mr_g_pkt0", 64'(opkt(0)), 64'({7'd0, 7'd0, 32'h30}));
      tick();
      chk("mr_g2_valid", 64'(wp_valid), 64'h1);
      chk("mr_g2_src0", 64'(osrc(0)), 64'h2);

      // Mispredict on checkpoint 2 kills buffered and incoming mask-04 entries
      do_reset();
      req_valid = 4'b1011;
      drive(0, mk(8'h01, 7'd0, 7'd0, 32'h10));
      drive(1, mk(8'h04, 7'd1, 7'd0, 32'h11));
      drive(3, mk(8'h04, 7'd3, 7'd0, 32'h13));
      tick();
      idle_inputs();
      req_valid = 4'b0100;
      drive(2, mk(8'h04, 7'd2, 7'd0, 32'h12));
      ctrl_v  = 1'b1;
      ctrl_m  = 1'b1;
      ctrl_id = 3'd2;
      tick();
      idle_inputs();
      chk("sq_valid", 64'(wp_valid), 64'h1);
      chk("sq_src0", 64'(osrc(0)), 64'h0);
      chk("sq_pkt0", 64'(opkt(0)), 64'({7'd0, 7'd0, 32'h10}));
      chk("sq_pkt1_hold", 64'(opkt(1)), 64'h0);
      chk("sq_count", 64'(perf_squash), PerfEn ? 64'd3 : 64'd0);
      tick();
      chk("sq_after1_valid", 64'(wp_valid), 64'h0);
      tick();
      chk("sq_after2_valid", 64'(wp_valid), 64'h0);
      chk("sq_ready", 64'(req_ready), 64'hF);

      // Correct resolution clears the stored bit, so a later mispredict spares it
      do_reset();
      req_valid = 4'b0111;
      drive(0, mk(8'h00, 7'd0, 7'd0, 32'h20));
      drive(1, mk(8'h00, 7'd1, 7'd0, 32'h21));
      drive(2, mk(8'h04, 7'd2, 7'd9, 32'h22));
      tick();
      idle_inputs();
      ctrl_v  = 1'b1;
      ctrl_m  = 1'b0;
      ctrl_id = 3'd2;
      tick();
      chk("cr_valid", 64'(wp_valid), 64'h3);
      chk("cr_src0", 64'(osrc(0)), 64'h0);
      chk("cr_src1", 64'(osrc(1)), 64'h1);
      ctrl_v  = 1'b1;
      ctrl_m  = 1'b1;
      ctrl_id = 3'd2;
      tick();
      idle_inputs();
      chk("cr_survive_valid", 64'(wp_valid), 64'h1);
      chk("cr_survive_src0", 64'(osrc(0)), 64'h2);
      chk("cr_survive_pkt0", 64'(opkt(0)), 64'({7'd2, 7'd9, 32'h22}));
      chk("cr_squash", 64'(perf_squash), 64'h0);
      tick();
      chk("cr_idle_valid", 64'(wp_valid), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name:
wb_port_arbiter

Overview:
- Shares the physical-register-file write ports among the execution-side result producers: FU0–FU2 and the LSU.
- Each producer gets a small per-requester skid FIFO. A round-robin scheduler grants up to NUM_WP heads per cycle onto registered write-port packets.
- Sits between the execute/LSU output stage and the register-file write / writeback stage.
- Honours branch-mask squash on mispredict and clears mask bits on correct branch resolution.

Parameters:
NUM_REQ, 4, number of result requesters (FU0..FU2, LSU)
NUM_WP, 2, number of register-file write ports
BUF_DEPTH, 2, skid FIFO entries per requester (power of 2, >=2)
DATA_W, 32, result data width
PHYS_W, 7, physical register tag width
AL_W, 7, active-list index width
CKPT, 8, branch checkpoints (branch-mask width)
CKPT_LOG, 3, log2(CKPT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester result valid
req_packet_i  in  NUM_REQ*(CKPT+PHYS_W+AL_W+DATA_W)  per-requester {brMask, phyDest, alId, data}; requester r occupies slice r
req_ready_o  out  NUM_REQ  requester r may push this cycle
ctrlVerified_i  in  1  branch resolved this cycle
ctrlMispredict_i  in  1  resolved branch mispredicted
ctrlSMTid_i  in  CKPT_LOG  checkpoint id of resolved branch
wp_valid_o  out  NUM_WP  write-port packet valid
wp_packet_o  out  NUM_WP*(PHYS_W+AL_W+DATA_W)  {phyDest, alId, data} per port
wp_src_o  out  NUM_WP*2  requester index driving each port
perf_stall_o  out  32  stall-cycle counter (see Optional Feature)
perf_squash_o  out  32  squashed-entry counter (see Optional Feature)

Behaviour:
- Reset (clk edge with reset=1):
  - All FIFOs empty; all entry valid bits 0.
  - rr_ptr=0; wp_valid_o=0; wp_packet_o=0; wp_src_o=0; perf counters 0.
- req_ready_o[r] = (count[r] < BUF_DEPTH). It is combinational from registered count only and never depends on req_valid_i.
- Push:
  - When req_valid_i[r] && req_ready_o[r], the packet is written at the tail.
  - If req_valid_i[r] is high while ready is low, the packet is ignored; the requester holds.
- Branch mask handling, every cycle, applied to every buffered entry and to the incoming packet:
  - Mispredict = ctrlVerified_i && ctrlMispredict_i. Entries whose brMask[ctrlSMTid_i] is set are invalidated. An incoming packet with that bit set is pushed with its valid bit cleared.
  - Correct = ctrlVerified_i && !ctrlMispredict_i. Bit ctrlSMTid_i is cleared in all stored masks and in the incoming mask before it is written.
- Head handling:
  - An invalid head is popped without a grant, at most one pop per requester per cycle.
  - Eligible heads = valid heads not squashed this cycle.
- Arbitration:
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first NUM_WP eligible heads are granted to ports 0..NUM_WP-1 in scan order.
  - At most one grant per requester per cycle. Granted heads pop.
- rr_ptr update:
  - If at least one grant: rr_ptr = (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
- Latency: grant in cycle t; wp_valid_o/wp_packet_o/wp_src_o registered at t+1. Minimum push-to-output latency is 2 cycles.
- Output: ports not granted have wp_valid_o=0 and their packet holds its previous value. The output register is not squashed after grant.
- Simultaneous push and pop on the same requester: count is unchanged, FIFO order is preserved, and the write and read pointers wrap modulo BUF_DEPTH.
- Push into an empty FIFO is not eligible the same cycle; there is no bypass.
- Reset asserted mid-operation discards all buffered and in-flight packets. The next cycle has all outputs at their reset values.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined:
  - perf_stall_o increments once per cycle in which any requester has req_valid_i=1 with req_ready_o=0.
  - perf_squash_o increments by the number of entries, buffered or incoming, invalidated by mispredict that cycle.
  - Both counters saturate at 2^32-1 and clear on reset.
- When undefined: both outputs are tied to 0 and no counter logic is instantiated.

Test Plan:
- Push into requester 0 only with alId=5, data=0xA5 -> wp_valid_o=2'b01 two cycles after the push; wp_src_o port0=0; packet data 0xA5.
- All 4 requesters push every cycle (NUM_WP=2) -> each requester granted exactly every other cycle in order {0,1},{2,3},{0,1}... Ready deasserts once FIFOs reach 2 and traffic sustains 2 packets/cycle.
- Requesters 1 and 3 buffer entries with brMask=8'h04; assert ctrlVerified_i=1, ctrlMispredict_i=1, ctrlSMTid_i=2 -> those entries never appear on wp_valid_o; an entry with mask 8'h01 is still granted. With the macro defined, perf_squash_o increases by the squashed count.
- Buffered entry has mask 8'h04; correct resolution of id 2, then mispredict of id 2 -> entry survives and is written out.
- Fill requester 2 to BUF_DEPTH and hold req_valid_i -> req_ready_o[2]=0, no overwrite, FIFO order preserved after wrap (sequence 1..6 exits in order).
- Assert reset with all FIFOs full -> next cycle wp_valid_o=0, all req_ready_o=1, rr_ptr=0 (the first grant after reset goes to requester 0).
